reg_file_mp: RTL and testbench

- Parametrised successor to the single-cycle CPU register file: configurable data width, address width and number of read ports.
- Registered reads and a posedge write port with optional write-to-read bypass.
- A reset-driven clear sequencer walks every entry to its init value, so power-up contents need no initial blocks.
- Sits between decode and ALU/writeback; NUM_READ=3 serves store-with-index and future pipelined cores.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/reg_file_rd_port.sv | 60 ++++++
 rtl/reg_file_mp.sv | 91 +++++++++
 tb/tb_reg_file_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register file.
// Contents: default widths, architectural register indices, the stack-pointer
// reset value and the register-file sequencer state enum.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;

   localparam logic [31:0] SP_RESET_VAL = 32'h00001FFF;

   typedef enum logic {
      RF_CLEAR,
      RF_RUN
   } rf_state_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of the register file.
// Ports:
//   clk      - clock
//   clr      - synchronous clear of the output register (reset or clear sequence)
//   en       - capture enable; 0 holds data
//   addr     - read index
//   mem_data - array contents at addr
//   wr_en    - write taking effect on this edge
//   wr_addr  - write index
//   wr_data  - write data
//   data     - registered read data
// Build option: REG_FILE_WRITE_BYPASS_EN selects write-first on a same-edge
// read/write of the same index; otherwise the port returns the old contents.
module reg_file_rd_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] rd_val;

`ifdef REG_FILE_WRITE_BYPASS_EN
   always_comb begin
      rd_val = mem_data;
      if (wr_en && (wr_addr == addr))
         rd_val = wr_data;
      // index 0 masking wins over the bypass
      if (addr == ADDR_W'(REG_ZERO))
         rd_val = '0;
   end
`else
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};

   always_comb begin
      rd_val = mem_data;
      if (addr == ADDR_W'(REG_ZERO))
         rd_val = '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (clr)
         data <= '0;
      else if (en)
         data <= rd_val;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads and a clear sequencer.
// After reset release every entry is walked to its init value (zero, or
// SP_INIT at SP_INDEX), one per clock, while Busy is high.
// Ports:
//   Clock      - sole clock
//   Reset_N    - synchronous active-low reset; restarts the clear sequence
//   Read_Reg   - read indices, port k at [k*ADDR_W +: ADDR_W]
//   Read_En    - per-port capture enable
//   Read_Data  - registered read data, port k at [k*DATA_W +: DATA_W]
//   Write_Reg  - write index
//   Write_Data - write data
//   Reg_Write  - write enable
//   Busy       - clear sequence running; writes ignored, reads return 0
// Build option: REG_FILE_WRITE_BYPASS_EN (write-first same-edge bypass).
module reg_file_mp
   import cpu_pkg::*;
#(
   parameter int          DATA_W   = DATA_W_DEF,
   parameter int          ADDR_W   = ADDR_W_DEF,
   parameter int          NUM_READ = 2,
   parameter int          SP_INDEX = REG_SP,
   parameter logic [31:0] SP_INIT  = SP_RESET_VAL
) (
   input  logic                       Clock,
   input  logic                       Reset_N,
   input  logic [NUM_READ*ADDR_W-1:0] Read_Reg,
   input  logic [NUM_READ-1:0]        Read_En,
   output logic [NUM_READ*DATA_W-1:0] Read_Data,
   input  logic [ADDR_W-1:0]          Write_Reg,
   input  logic [DATA_W-1:0]          Write_Data,
   input  logic                       Reg_Write,
   output logic                       Busy
);

   localparam int                DEPTH  = 2**ADDR_W;
   localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

   rf_state_t         state;
   logic [ADDR_W-1:0] clr_idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              write_ok;
   logic              rd_clr;

   assign write_ok = (state == RF_RUN) && Reg_Write && (Write_Reg != ADDR_W'(REG_ZERO));
   assign rd_clr   = !Reset_N || (state == RF_CLEAR);

   always_ff @(posedge Clock) begin
      if (!Reset_N) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
         Busy    <= 1'b1;
      end else if (state == RF_CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == '1) begin
            state <= RF_RUN;
            Busy  <= 1'b0;
         end
      end
   end

   // The array has no reset: the clear sequence is what initialises it.
   always_ff @(posedge Clock) begin
      if (Reset_N) begin
         if (state == RF_CLEAR)
            mem[clr_idx] <= (clr_idx == ADDR_W'(SP_INDEX)) ? SP_VAL : '0;
         else if (write_ok)
            mem[Write_Reg] <= Write_Data;
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      assign rd_addr = Read_Reg[k*ADDR_W +: ADDR_W];

      reg_file_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd_port (
         .clk      (Clock),
         .clr      (rd_clr),
         .en       (Read_En[k]),
         .addr     (rd_addr),
         .mem_data (mem[rd_addr]),
         .wr_en    (write_ok),
         .wr_addr  (Write_Reg),
         .wr_data  (Write_Data),
         .data     (Read_Data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (3 read ports, default widths).
module tb_reg_file_mp;

   localparam int NR = 3;

   logic          Clock;
   logic          Reset_N;
   logic [NR*5-1:0] Read_Reg;
   logic [NR-1:0] Read_En;
   logic [NR*32-1:0] Read_Data;
   logic [4:0]    Write_Reg;
   logic [31:0]   Write_Data;
   logic          Reg_Write;
   logic          Busy;

   reg_file_mp #(.NUM_READ(NR)) dut (
      .Clock      (Clock),
      .Reset_N    (Reset_N),
      .Read_Reg   (Read_Reg),
      .Read_En    (Read_En),
      .Read_Data  (Read_Data),
      .Write_Reg  (Write_Reg),
      .Write_Data (Write_Data),
      .Reg_Write  (Reg_Write),
      .Busy       (Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

`ifdef REG_FILE_WRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: architectural contents plus clear progress
   logic [31:0] m_mem [32];
   logic [31:0] m_rd  [NR];
   bit          m_valid = 1'b0;
   bit          m_busy  = 1'b0;
   int          m_left  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_port(input int k);
      return Read_Data[k*32 +: 32];
   endfunction

   // Expected effect of one clock edge given the inputs currently applied.
   task automatic model_edge();
      logic [4:0] ra;
      if (!Reset_N) begin
         m_valid = 1'b1;
         m_busy  = 1'b1;
         m_left  = 32;
         foreach (m_rd[k]) m_rd[k] = '0;
      end else if (m_valid && m_busy) begin
         // entries are cleared in ascending order, so the next is 32-m_left
         m_mem[32 - m_left] = (32 - m_left == 29) ? 32'h00001FFF : 32'h0;
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
         foreach (m_rd[k]) m_rd[k] = '0;
      end else if (m_valid) begin
         for (int k = 0; k < NR; k++) begin
            ra = Read_Reg[k*5 +: 5];
            if (Read_En[k]) begin
               if (ra == 0)
                  m_rd[k] = '0;
               else if (BYPASS && Reg_Write && Write_Reg == ra)
                  m_rd[k] = Write_Data;
               else
                  m_rd[k] = m_mem[ra];
            end
         end
         if (Reg_Write && Write_Reg != 0)
            m_mem[Write_Reg] = Write_Data;
      end
   endtask

   task automatic cycle();
      @(posedge Clock);
      model_edge();
      #1;
      if (m_valid) begin
         check("busy_model", {31'b0, Busy}, {31'b0, m_busy});
         for (int k = 0; k < NR; k++)
            check($sformatf("rd%0d_model", k), rd_port(k), m_rd[k]);
      end
   endtask

   task automatic count_busy(input string name, input int exp);
      int n = 0;
      while (Busy === 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      check(name, n, exp);
   endtask

   typedef struct {
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra [NR];
      logic [NR-1:0] en;
      logic [31:0] exp [NR];
   } vec_t;

   vec_t vecs [12];
   logic [31:0] r9_same, r10_same;

   initial begin
      foreach (m_mem[i]) m_mem[i] = '0;
      foreach (m_rd[i])  m_rd[i]  = '0;
      Reset_N = 1'b0; Read_Reg = '0; Read_En = '1;
      Write_Reg = '0; Write_Data = '0; Reg_Write = 1'b0;

      r9_same  = BYPASS ? 32'h2 : 32'h1;
      r10_same = BYPASS ? 32'h7 : 32'h5;
      vecs[0]  = '{1, 5'd8,  32'hDEADBEEF, '{29, 17, 0}, 3'b111, '{32'h1FFF, 0, 0}};
      vecs[1]  = '{0, 5'd0,  32'h0,        '{8, 8, 0},   3'b111, '{32'hDEADBEEF, 32'hDEADBEEF, 0}};
      vecs[2]  = '{1, 5'd0,  32'hFFFFFFFF, '{0, 0, 0},   3'b111, '{0, 0, 0}};
      vecs[3]  = '{0, 5'd0,  32'h0,        '{0, 0, 0},   3'b111, '{0, 0, 0}};
      vecs[4]  = '{1, 5'd9,  32'h1,        '{8, 29, 17}, 3'b111, '{32'hDEADBEEF, 32'h1FFF, 0}};
      vecs[5]  = '{1, 5'd9,  32'h2,        '{9, 9, 9},   3'b111, '{r9_same, r9_same, r9_same}};
      vecs[6]  = '{0, 5'd0,  32'h0,        '{9, 9, 9},   3'b111, '{2, 2, 2}};
      vecs[7]  = '{1, 5'd10, 32'h5,        '{0, 0, 0},   3'b111, '{0, 0, 0}};
      vecs[8]  = '{0, 5'd0,  32'h0,        '{10, 10, 10}, 3'b111, '{5, 5, 5}};
      vecs[9]  = '{1, 5'd10, 32'h7,        '{10, 10, 10}, 3'b101, '{r10_same, 5, r10_same}};
      vecs[10] = '{0, 5'd0,  32'h0,        '{10, 10, 10}, 3'b101, '{7, 5, 7}};
      vecs[11] = '{0, 5'd0,  32'h0,        '{10, 10, 10}, 3'b111, '{7, 7, 7}};

      // power-up reset: 3 cycles low, then exactly 32 busy edges
      repeat (3) cycle();
      check("busy_in_reset", {31'b0, Busy}, 32'h1);
      Reset_N = 1'b1;
      count_busy("busy_len_first", 32);

      foreach (vecs[i]) begin
         Reg_Write = vecs[i].we; Write_Reg = vecs[i].wa; Write_Data = vecs[i].wd;
         Read_En = vecs[i].en;
         for (int k = 0; k < NR; k++) Read_Reg[k*5 +: 5] = vecs[i].ra[k];
         cycle();
         for (int k = 0; k < NR; k++)
            check($sformatf("vec%0d_rd%0d", i, k), rd_port(k), vecs[i].exp[k]);
      end

      // random traffic with occasional resets, biased towards same-index hits
      for (int c = 0; c < 800; c++) begin
         Reset_N    = ($urandom_range(0, 99) != 0);
         Reg_Write  = $urandom_range(0, 1);
         Write_Reg  = 5'($urandom_range(0, 31));
         Write_Data = $urandom;
         Read_En    = NR'($urandom_range(0, 7));
         for (int k = 0; k < NR; k++)
            Read_Reg[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? Write_Reg : 5'($urandom_range(0, 31));
         cycle();
      end
      Reset_N = 1'b1; Reg_Write = 1'b0; Read_En = '1;
      begin
         int n = 0;
         while (Busy === 1'b1 && n < 100) begin cycle(); n++; end
      end
      check("idle_after_random", {31'b0, Busy}, 32'h0);

      // reset in the middle of a clear restarts the full sequence
      Reg_Write = 1'b1; Write_Reg = 5'd8; Write_Data = 32'h55;
      cycle();
      Reg_Write = 1'b0; Read_Reg = {5'd0, 5'd0, 5'd8};
      cycle();
      check("r8_written", rd_port(0), 32'h55);
      Reset_N = 1'b0;
      cycle();
      Reset_N = 1'b1;
      repeat (10) cycle();
      Reset_N = 1'b0; Reg_Write = 1'b1; Write_Reg = 5'd5; Write_Data = 32'hAAAA5555;
      cycle();
      Reset_N = 1'b1;
      count_busy("busy_len_restart", 32);
      Reg_Write = 1'b0; Read_Reg = {5'd5, 5'd29, 5'd8};
      cycle();
      check("r8_after_clear", rd_port(0), 32'h0);
      check("r29_after_clear", rd_port(1), 32'h00001FFF);
      check("r5_write_ignored", rd_port(2), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
